cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle control FSM for the 16-bit CPU datapath. Sequences fetch, decode, execute and writeback, and drives:
//  - PC enable/load, IR enable, register-file write enable, flag-register enable
//  - ALU_Bus source select, BRAM port-A address select and write enable
//  Reads the IR output and the flag register; holds no datapath state except its FSM and a retire counter.
// PARAMETERS
//  RETIRE_W  16  width of retired-instruction counter (wraps)
// PORTS
//  clk        in   1         system clock, all state on posedge
//  reset      in   1         asynchronous, active-low reset
//  run        in   1         1 = execute continuously; 0 = stop at next instruction boundary
//  step       in   1         single-step request (used only with CPU_SEQ_STEP_EN)
//  instr      in   16        IR output; valid from the cycle after ir_en
//  flags      in   5         flag register {C,L,F,Z,N} = [4:0]
//  pc_en      out  1         PC <= PC+1
//  pc_ld      out  1         PC <= branch target
//  pc_src     out  1         0 = target from Rtarget register, 1 = PC + sign-ext disp
//  ir_en      out  1         IR <= BRAM q_a
//  rf_we      out  1         write ALU_Bus into register Rdest
//  flags_en   out  1         flag register <= ALU flags
//  bus_sel    out  2         ALU_Bus source: 00 BRAM q_a, 01 ALU, 10 PC+1 (link)
//  addr_sel   out  1         BRAM addr_a: 0 = PC, 1 = Raddr register
//  we_a       out  1         BRAM port-A write
//  halted     out  1         illegal instruction trap
//  retired    out  RETIRE_W  retired-instruction count
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE; all outputs 0; retired=0; in-flight instruction abandoned.
//  - Outputs decode combinationally from state + instr, so we_a drops in the reset-assert cycle.
//  - Decode fields: hi=instr[15:12], ext=instr[7:4], cond=instr[11:8].
//    - LOAD: hi=0100, ext=0000
//    - STOR: hi=0100, ext=0100
//    - JAL: hi=0100, ext=1000
//    - Jcond: hi=0100, ext=1100
//    - Bcond: hi=1100
//    - Any other hi=0100 ext, or hi=1110: illegal
//    - All remaining encodings: ALU class
//  - States and transitions:
//    - IDLE: all outputs 0. Go to FETCH when run=1.
//    - FETCH: addr_sel=0; BRAM 1-cycle read of mem[PC]. Go to DECODE.
//    - DECODE: ir_en=1. Go to EXEC.
//    - EXEC, ALU class: bus_sel=01, pc_en=1.
//      - rf_we=1 except CMP (hi=0000 ext=1011) and CMPI (hi=1011).
//      - flags_en=1 except MOV (hi=0000 ext=1101), MOVI (hi=1101) and LUI (hi=1111).
//      - Retire.
//    - EXEC, LOAD: addr_sel=1. Go to LOAD_WB.
//    - EXEC, STOR: addr_sel=1, we_a=1 for exactly one cycle, pc_en=1. Retire.
//    - EXEC, JAL: bus_sel=10, rf_we=1, pc_ld=1, pc_src=0. Retire.
//    - EXEC, Jcond/Bcond taken: pc_ld=1, pc_src=0 (Jcond) or 1 (Bcond). Not taken: pc_en=1. Retire.
//    - EXEC, illegal: go to HALT.
//    - LOAD_WB: addr_sel=1, bus_sel=00, rf_we=1, pc_en=1. Retire.
//    - HALT: halted=1, all other outputs 0. Leaves only via reset.
//  - Retire: retired <= retired+1 (wraps at 2^RETIRE_W). Next state FETCH if run=1, else IDLE.
//  - Latency: 3 cycles per instruction; LOAD takes 4. pc_en and pc_ld are never both 1.
//  - Conditions, cond -> taken when:
//    - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N
//    - 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z
//    - E always; F never
//  - Flags are sampled in EXEC; a flag write in the same cycle takes effect for the next instruction.
//  - run deasserted mid-instruction: the current instruction completes, then IDLE.
// CONFIGURATION
//  CPU_SEQ_STEP_EN defined:
//  - step is registered; a rising edge seen in IDLE starts exactly one instruction.
//  - Return to IDLE after it unless run=1.
//  - step edges outside IDLE are ignored, not queued.
//  CPU_SEQ_STEP_EN undefined: step ignored; behaviour as above.
// TESTING
//  1. reset=0 then 1, run=1, instr=0x0152 (ALU ADD).
//     -> IDLE, FETCH, DECODE(ir_en), EXEC with rf_we, flags_en, bus_sel=01, pc_en.
//     -> retired=1 after 4 cycles from reset release.
//  2. LOAD 0x4300, then STOR 0x4341.
//     -> LOAD: EXEC addr_sel=1 we_a=0; LOAD_WB rf_we=1 bus_sel=00; 4 cycles.
//     -> STOR: we_a=1 for one cycle, rf_we=0; 3 cycles.
//  3. Bcond 0xC0xx: cond=0 with flags=00010 (Z=1) -> pc_ld=1, pc_src=1, pc_en=0.
//     Same with Z=0 -> pc_en=1, pc_ld=0. cond=F -> never taken; cond=E -> always taken.
//  4. Illegal 0x4020 -> HALT; halted=1 held for 20 cycles with no enables, retired frozen.
//     reset=0 -> halted=0, state IDLE.
//  5. reset=0 asynchronously in STOR EXEC -> we_a=0 in the same cycle, retired=0; run=0 mid-ALU -> retires, then IDLE.
//  6. CPU_SEQ_STEP_EN, run=0: one step pulse -> exactly one retire, then IDLE.
//     A second pulse during EXEC is ignored. Without the macro -> no retire.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the CPU sequencer and the 16-bit datapath.
// master = sequencer (drives enables/selects), slave = datapath (drives IR and flags).
interface cpu_sequencer_if;
    logic [15:0] instr;
    logic [4:0]  flags;
    logic        pc_en;
    logic        pc_ld;
    logic        pc_src;
    logic        ir_en;
    logic        rf_we;
    logic        flags_en;
    logic [1:0]  bus_sel;
    logic        addr_sel;
    logic        we_a;

    modport master (
        input  instr, flags,
        output pc_en, pc_ld, pc_src, ir_en, rf_we, flags_en, bus_sel, addr_sel, we_a
    );
    modport slave (
        output instr, flags,
        input  pc_en, pc_ld, pc_src, ir_en, rf_we, flags_en, bus_sel, addr_sel, we_a
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control FSM with a retire counter.
// Optional single-step support is built when CPU_SEQ_STEP_EN is defined.
module cpu_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                step,
    cpu_sequencer_if.master     bus,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_LOAD_WB, S_HALT
    } state_t;

    state_t                state_reg, state_next;
    logic [RETIRE_W-1:0]   retired_reg;
    logic                  retire;
    logic                  step_start;

    logic [3:0] hi, ext, cond;
    logic       is_mem, is_load, is_stor, is_jal, is_jcond, is_bcond, is_illegal;
    logic       no_rf_write, no_flag_write, taken;

    logic       pc_en, pc_ld, pc_src, ir_en, rf_we, flags_en, addr_sel, we_a, halt_out;
    logic [1:0] bus_sel;

`ifdef CPU_SEQ_STEP_EN
    // Edge is taken against the previous-cycle level, so a pulse outside IDLE is gone by then.
    logic step_reg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) step_reg <= 1'b0;
        else        step_reg <= step;
    end
    assign step_start = step & ~step_reg;
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.instr[3:0]};
`else
    assign step_start = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, step, bus.instr[3:0]};
`endif

    assign hi   = bus.instr[15:12];
    assign ext  = bus.instr[7:4];
    assign cond = bus.instr[11:8];

    assign is_mem     = (hi == 4'h4);
    assign is_load    = is_mem && (ext == 4'h0);
    assign is_stor    = is_mem && (ext == 4'h4);
    assign is_jal     = is_mem && (ext == 4'h8);
    assign is_jcond   = is_mem && (ext == 4'hC);
    assign is_bcond   = (hi == 4'hC);
    assign is_illegal = (is_mem && !(is_load || is_stor || is_jal || is_jcond)) || (hi == 4'hE);

    // CMP/CMPI only update flags; MOV/MOVI/LUI only write the register.
    assign no_rf_write   = ((hi == 4'h0) && (ext == 4'hB)) || (hi == 4'hB);
    assign no_flag_write = ((hi == 4'h0) && (ext == 4'hD)) || (hi == 4'hD) || (hi == 4'hF);

    // flags = {C, L, F, Z, N}
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            4'h0: taken = bus.flags[1];
            4'h1: taken = !bus.flags[1];
            4'h2: taken = bus.flags[4];
            4'h3: taken = !bus.flags[4];
            4'h4: taken = bus.flags[3];
            4'h5: taken = !bus.flags[3];
            4'h6: taken = bus.flags[0];
            4'h7: taken = !bus.flags[0];
            4'h8: taken = bus.flags[2];
            4'h9: taken = !bus.flags[2];
            4'hA: taken = !bus.flags[3] && !bus.flags[1];
            4'hB: taken = bus.flags[3] || bus.flags[1];
            4'hC: taken = !bus.flags[0] && !bus.flags[1];
            4'hD: taken = bus.flags[0] || bus.flags[1];
            4'hE: taken = 1'b1;
            4'hF: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) retired_reg <= retired_reg + RETIRE_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        pc_en      = 1'b0;
        pc_ld      = 1'b0;
        pc_src     = 1'b0;
        ir_en      = 1'b0;
        rf_we      = 1'b0;
        flags_en   = 1'b0;
        bus_sel    = 2'b00;
        addr_sel   = 1'b0;
        we_a       = 1'b0;
        halt_out   = 1'b0;
        unique case (state_reg)
            S_IDLE:   if (run || step_start) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                ir_en      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_illegal) begin
                    state_next = S_HALT;
                end else if (is_load) begin
                    addr_sel   = 1'b1;
                    state_next = S_LOAD_WB;
                end else if (is_stor) begin
                    addr_sel = 1'b1;
                    we_a     = 1'b1;
                    pc_en    = 1'b1;
                    retire   = 1'b1;
                end else if (is_jal) begin
                    bus_sel = 2'b10;
                    rf_we   = 1'b1;
                    pc_ld   = 1'b1;
                    retire  = 1'b1;
                end else if (is_jcond || is_bcond) begin
                    if (taken) begin
                        pc_ld  = 1'b1;
                        pc_src = is_bcond;
                    end else begin
                        pc_en = 1'b1;
                    end
                    retire = 1'b1;
                end else begin
                    bus_sel  = 2'b01;
                    pc_en    = 1'b1;
                    rf_we    = !no_rf_write;
                    flags_en = !no_flag_write;
                    retire   = 1'b1;
                end
            end
            S_LOAD_WB: begin
                addr_sel = 1'b1;
                rf_we    = 1'b1;
                pc_en    = 1'b1;
                retire   = 1'b1;
            end
            S_HALT:  halt_out = 1'b1;
            default: state_next = S_IDLE;
        endcase
        if (retire) state_next = run ? S_FETCH : S_IDLE;
    end

    assign bus.pc_en    = pc_en;
    assign bus.pc_ld    = pc_ld;
    assign bus.pc_src   = pc_src;
    assign bus.ir_en    = ir_en;
    assign bus.rf_we    = rf_we;
    assign bus.flags_en = flags_en;
    assign bus.bus_sel  = bus_sel;
    assign bus.addr_sel = addr_sel;
    assign bus.we_a     = we_a;
    assign halted       = halt_out;
    assign retired      = retired_reg;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed vector bench for cpu_sequencer: per-instruction control patterns plus
// halt, async-reset, run-drop and single-step sequences.
module tb_cpu_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        halted;
    logic [15:0] retired;
    int          errors = 0;
    int          checks = 0;

    cpu_sequencer_if bi ();

    cpu_sequencer #(.RETIRE_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .bus(bi.master), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // Packed control word: {halted, pc_en, pc_ld, pc_src, ir_en, rf_we, flags_en, bus_sel, addr_sel, we_a}
    localparam logic [10:0] H  = 11'h400, PE = 11'h200, PL = 11'h100, PS = 11'h080;
    localparam logic [10:0] IR = 11'h040, RF = 11'h020, FE = 11'h010;
    localparam logic [10:0] BA = 11'h004, BL = 11'h008, AS = 11'h002, WE = 11'h001;

`ifdef CPU_SEQ_STEP_EN
    localparam logic [15:0] STEP_RETIRES = 16'd1;
`else
    localparam logic [15:0] STEP_RETIRES = 16'd0;
`endif

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [10:0] exp_exec;
        int          kind;      // 0 single-exec, 1 load, 2 illegal
    } vec_t;

    vec_t vecs [19];

    function automatic logic [10:0] ctrl();
        return {halted, bi.pc_en, bi.pc_ld, bi.pc_src, bi.ir_en, bi.rf_we, bi.flags_en,
                bi.bus_sel, bi.addr_sel, bi.we_a};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset with stimulus applied, then release it on a negedge.
    task automatic restart(input logic [15:0] ins, input logic [4:0] fl, input logic r);
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        step = 1'b0;
        bi.instr = ins;
        bi.flags = fl;
        @(negedge clk);
        reset = 1'b1;
        run = r;
    endtask

    initial begin
        bi.instr = 16'h0;
        bi.flags = 5'h0;

        vecs[0]  = '{16'h0152, 5'b00000, PE|RF|FE|BA, 0};   // ADD
        vecs[1]  = '{16'h00B2, 5'b00000, PE|FE|BA,    0};   // CMP
        vecs[2]  = '{16'hB005, 5'b00000, PE|FE|BA,    0};   // CMPI
        vecs[3]  = '{16'h00D1, 5'b00000, PE|RF|BA,    0};   // MOV
        vecs[4]  = '{16'hD012, 5'b00000, PE|RF|BA,    0};   // MOVI
        vecs[5]  = '{16'hF0AA, 5'b00000, PE|RF|BA,    0};   // LUI
        vecs[6]  = '{16'h4300, 5'b00000, AS,          1};   // LOAD
        vecs[7]  = '{16'h4341, 5'b00000, AS|WE|PE,    0};   // STOR
        vecs[8]  = '{16'h4582, 5'b00000, BL|RF|PL,    0};   // JAL
        vecs[9]  = '{16'hC005, 5'b00010, PL|PS,       0};   // BEQ, Z=1
        vecs[10] = '{16'hC005, 5'b00000, PE,          0};   // BEQ, Z=0
        vecs[11] = '{16'hCF00, 5'b11111, PE,          0};   // never
        vecs[12] = '{16'hCE00, 5'b00000, PL|PS,       0};   // always
        vecs[13] = '{16'h4AC3, 5'b00000, PL,          0};   // JLO, !L&!Z
        vecs[14] = '{16'h4DC0, 5'b00000, PE,          0};   // JGE, N|Z false
        vecs[15] = '{16'hC610, 5'b00001, PL|PS,       0};   // BGT, N=1
        vecs[16] = '{16'hC310, 5'b10000, PE,          0};   // BCC, C=1
        vecs[17] = '{16'h4020, 5'b00000, 11'h000,     2};   // illegal ext
        vecs[18] = '{16'hE000, 5'b00000, 11'h000,     2};   // illegal hi

        for (int i = 0; i < 19; i++) begin
            restart(vecs[i].instr, vecs[i].flags, 1'b1);
            chk($sformatf("v%0d idle ctrl", i), {5'h0, ctrl()}, 16'h0);
            chk($sformatf("v%0d reset retired", i), retired, 16'h0);
            tick();
            chk($sformatf("v%0d fetch", i), {5'h0, ctrl()}, 16'h0);
            tick();
            chk($sformatf("v%0d decode", i), {5'h0, ctrl()}, {5'h0, IR});
            tick();
            chk($sformatf("v%0d exec", i), {5'h0, ctrl()}, {5'h0, vecs[i].exp_exec});
            if (vecs[i].kind == 1) begin
                tick();
                chk($sformatf("v%0d load_wb", i), {5'h0, ctrl()}, {5'h0, AS|RF|PE});
                chk($sformatf("v%0d load_wb retired", i), retired, 16'h0);
            end
            tick();
            if (vecs[i].kind == 2) begin
                chk($sformatf("v%0d halted", i), {5'h0, ctrl()}, {5'h0, H});
                chk($sformatf("v%0d halt retired", i), retired, 16'h0);
            end else begin
                chk($sformatf("v%0d retired", i), retired, 16'h1);
            end
        end

        // Illegal instruction: HALT is sticky and quiet until reset.
        restart(16'h4020, 5'b0, 1'b1);
        repeat (4) tick();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("halt hold c%0d", c), {5'h0, ctrl()}, {5'h0, H});
            chk($sformatf("halt retired c%0d", c), retired, 16'h0);
            tick();
        end
        #2 reset = 1'b0;
        #1 chk("halt async clear", {5'h0, ctrl()}, 16'h0);

        // Async reset during STOR EXEC of the second instruction.
        restart(16'h0152, 5'b0, 1'b1);
        repeat (4) tick();
        chk("seq2 first retire", retired, 16'h1);
        bi.instr = 16'h4341;
        tick();
        tick();
        chk("stor exec we_a", {5'h0, ctrl()}, {5'h0, AS|WE|PE});
        #2 reset = 1'b0;
        #1 chk("stor async we_a", {15'h0, bi.we_a}, 16'h0);
        chk("stor async retired", retired, 16'h0);

        // STOR we_a lasts exactly one cycle.
        restart(16'h4341, 5'b0, 1'b1);
        repeat (3) tick();
        chk("stor we_a on", {15'h0, bi.we_a}, 16'h1);
        tick();
        chk("stor we_a off", {15'h0, bi.we_a}, 16'h0);
        chk("stor 3 cycles", retired, 16'h1);

        // run dropped mid-instruction: completes, then parks in IDLE.
        restart(16'h0152, 5'b0, 1'b1);
        tick();
        tick();
        run = 1'b0;
        tick();
        chk("rundrop exec", {5'h0, ctrl()}, {5'h0, PE|RF|FE|BA});
        tick();
        chk("rundrop retired", retired, 16'h1);
        chk("rundrop idle", {5'h0, ctrl()}, 16'h0);
        repeat (3) tick();
        chk("rundrop stays", retired, 16'h1);
        chk("rundrop idle ctrl", {5'h0, ctrl()}, 16'h0);

        // Single step with run=0; a second pulse in EXEC must not start another.
        restart(16'h0152, 5'b0, 1'b0);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (6) tick();
        chk("step retired", retired, STEP_RETIRES);
        chk("step idle ctrl", {5'h0, ctrl()}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
